// File: rtl/sp_sched_pkg.sv
// ---------------------------------------------------------------------------
// sp_sched_pkg
//
// Shared definitions for the single-precision issue scheduler.
//   FP_LAT      : latency class of FP ops (result on rt_wb)
//   INT_LAT     : latency class of integer multiply ops (result on rt_int)
//   REG_ADDR_W  : register address width
//   sp_slot_t   : one in-flight tracker entry (valid, is_int, wr, rt)
//   slot_latency: latency of an entry given its class
// ---------------------------------------------------------------------------
package sp_sched_pkg;

    localparam int FP_LAT     = 6;
    localparam int INT_LAT    = 7;
    localparam int REG_ADDR_W = 7;

    typedef struct packed {
        logic                  valid;
        logic                  is_int;
        logic                  wr;
        logic [0:REG_ADDR_W-1] rt;
    } sp_slot_t;

    // An int entry completes one edge later than an FP entry issued at the
    // same time; every hazard window in the scheduler is derived from this.
    function automatic int slot_latency(input logic is_int);
        return is_int ? INT_LAT : FP_LAT;
    endfunction

endpackage

// File: rtl/sp_slot_match.sv
// ---------------------------------------------------------------------------
// sp_slot_match
//
// Combinational hazard check of one tracker slot against the instruction
// currently offered by decode.
//
// Parameters:
//   SLOT_IDX   : position of the checked entry in the tracker (0 = newest)
// Ports:
//   entry      : tracker entry held in this slot
//   ra/rb/rc_addr, ra/rb/rc_used : sources of the offered instruction
//   new_is_int, new_wr, new_rt   : class, write flag, destination of it
//   raw_hit    : entry is still pending and writes a source that is read
//   waw_hit    : int entry in slot 0 and FP op to the same destination
//                would complete on the same edge
//   port_hit   : shared write-port conflict (only with SP_WB_PORT_SHARE_EN)
//
// Configuration macro: SP_WB_PORT_SHARE_EN
// ---------------------------------------------------------------------------
module sp_slot_match
    import sp_sched_pkg::*;
#(
    parameter int SLOT_IDX = 0
) (
    input  sp_slot_t              entry,
    input  logic [0:REG_ADDR_W-1] ra_addr,
    input  logic [0:REG_ADDR_W-1] rb_addr,
    input  logic [0:REG_ADDR_W-1] rc_addr,
    input  logic                  ra_used,
    input  logic                  rb_used,
    input  logic                  rc_used,
    input  logic                  new_is_int,
    input  logic                  new_wr,
    input  logic [0:REG_ADDR_W-1] new_rt,
    output logic                  raw_hit,
    output logic                  waw_hit,
    output logic                  port_hit
);

    localparam bit IS_SLOT0 = (SLOT_IDX == 0);

    logic pending;
    logic src_match;
    logic slot0_int_writer;
    logic fp_writer;

    // An entry in slot i has been in flight for i+1 edges; a consumer that
    // would be accepted at the next edge sees the result only once i+1
    // reaches the entry's latency, so it is pending while i < L-1.
    always_comb begin
        pending          = entry.valid && entry.wr &&
                           (SLOT_IDX < (slot_latency(entry.is_int) - 1));
        src_match        = (ra_used && (ra_addr == entry.rt)) ||
                           (rb_used && (rb_addr == entry.rt)) ||
                           (rc_used && (rc_addr == entry.rt));
        raw_hit          = pending && src_match;

        // The FP op completes one edge earlier than int; an int op still in
        // slot 0 would therefore finish on the same edge as a new FP op.
        slot0_int_writer = IS_SLOT0 && entry.valid && entry.is_int && entry.wr;
        fp_writer        = !new_is_int && new_wr;
        waw_hit          = slot0_int_writer && fp_writer && (new_rt == entry.rt);
    end

`ifdef SP_WB_PORT_SHARE_EN
    // With a single shared write port, any simultaneous completion clashes
    // regardless of the addresses.
    assign port_hit = slot0_int_writer && fp_writer;
`else
    assign port_hit = 1'b0;
`endif

endmodule

// File: rtl/sp_issue_scheduler.sv
// ---------------------------------------------------------------------------
// sp_issue_scheduler
//
// Issue controller for the single-precision pipe. Sits between decode and
// the RF/FWD stage and gates every instruction with a valid/ready handshake.
// Accepted instructions enter a DEPTH-slot shift tracker; new instructions
// are held off until RAW, WAW and (optionally) write-port hazards clear.
//
// Parameters:
//   DEPTH   : tracker slots, must be at least INT_LAT
//   STALL_W : width of the saturating stall counter
// Ports:
//   clk             : pipeline clock, rising edge
//   reset           : asynchronous active-high, clears all state
//   issue_valid     : decode presents an instruction
//   issue_is_int    : 1 = integer mpy (latency 7), 0 = FP (latency 6)
//   issue_reg_write : instruction writes issue_rt_addr
//   issue_rt_addr   : destination register
//   ra/rb/rc_addr   : source registers
//   ra/rb/rc_used   : source is actually read
//   issue_ready     : scheduler accepts this cycle (independent of valid)
//   sp_fire         : issue_valid & issue_ready, qualifies the SP unit
//   busy            : any tracker slot valid (registered)
//   stall_count     : saturating count of stalled cycles (registered)
//
// Configuration macro: SP_WB_PORT_SHARE_EN (rt_wb and rt_int share one
// register-file write port).
// ---------------------------------------------------------------------------
module sp_issue_scheduler
    import sp_sched_pkg::*;
#(
    parameter int DEPTH   = 7,
    parameter int STALL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_is_int,
    input  logic                  issue_reg_write,
    input  logic [0:REG_ADDR_W-1] issue_rt_addr,
    input  logic [0:REG_ADDR_W-1] ra_addr,
    input  logic [0:REG_ADDR_W-1] rb_addr,
    input  logic [0:REG_ADDR_W-1] rc_addr,
    input  logic                  ra_used,
    input  logic                  rb_used,
    input  logic                  rc_used,
    output logic                  issue_ready,
    output logic                  sp_fire,
    output logic                  busy,
    output logic [0:STALL_W-1]    stall_count
);

    sp_slot_t         slots      [DEPTH];
    sp_slot_t         next_slots [DEPTH];
    sp_slot_t         new_entry;
    logic             next_busy;
    logic [DEPTH-1:0] raw_vec;
    logic [DEPTH-1:0] waw_vec;
    logic [DEPTH-1:0] port_vec;

    // One matcher per slot; each decides from its own index whether its
    // entry can still hurt the offered instruction.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        sp_slot_match #(
            .SLOT_IDX (g)
        ) u_match (
            .entry      (slots[g]),
            .ra_addr    (ra_addr),
            .rb_addr    (rb_addr),
            .rc_addr    (rc_addr),
            .ra_used    (ra_used),
            .rb_used    (rb_used),
            .rc_used    (rc_used),
            .new_is_int (issue_is_int),
            .new_wr     (issue_reg_write),
            .new_rt     (issue_rt_addr),
            .raw_hit    (raw_vec[g]),
            .waw_hit    (waw_vec[g]),
            .port_hit   (port_vec[g])
        );
    end

    // Ready depends only on tracker state and the offered fields, never on
    // issue_valid, so decode may look at it before committing.
    assign issue_ready = !(|raw_vec) && !(|waw_vec) && !(|port_vec);
    assign sp_fire     = issue_valid && issue_ready;

    // Next tracker contents: accepted op (or a bubble) enters slot 0 and
    // everything else moves one slot older; the oldest slot falls off.
    always_comb begin
        new_entry.valid  = 1'b1;
        new_entry.is_int = issue_is_int;
        new_entry.wr     = issue_reg_write;
        new_entry.rt     = issue_rt_addr;

        next_slots[0] = sp_fire ? new_entry : '0;
        for (int i = 1; i < DEPTH; i++) begin
            next_slots[i] = slots[i-1];
        end

        next_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            next_busy = next_busy | next_slots[i].valid;
        end
    end

    // Tracker, busy flag and the saturating stall counter all update on the
    // same edge that accepts an instruction, so back-to-back independent
    // ops go through with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            busy        <= 1'b0;
            stall_count <= '0;
        end else begin
            slots <= next_slots;
            busy  <= next_busy;
            if (issue_valid && !issue_ready && (stall_count != '1)) begin
                stall_count <= stall_count + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sp_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sp_issue_scheduler
//
// Directed bench for sp_issue_scheduler. The driver pushes the expected
// accept cycle and destination of every instruction into a scoreboard
// queue; a monitor pops and compares whenever sp_fire is seen. Register
// state (busy, stall_count, issue_ready) is checked directly.
// Honours SP_WB_PORT_SHARE_EN for the one expectation that depends on it.
// ---------------------------------------------------------------------------
module tb_sp_issue_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_is_int;
    logic       issue_reg_write;
    logic [0:6] issue_rt_addr;
    logic [0:6] ra_addr;
    logic [0:6] rb_addr;
    logic [0:6] rc_addr;
    logic       ra_used;
    logic       rb_used;
    logic       rc_used;
    logic       issue_ready;
    logic       sp_fire;
    logic       busy;
    logic [0:15] stall_count;

    typedef struct {
        int         cyc;
        logic [6:0] rt;
    } exp_t;

    exp_t sb_queue[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   model_stalls = 0;

    sp_issue_scheduler #(
        .DEPTH   (7),
        .STALL_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_is_int    (issue_is_int),
        .issue_reg_write (issue_reg_write),
        .issue_rt_addr   (issue_rt_addr),
        .ra_addr         (ra_addr),
        .rb_addr         (rb_addr),
        .rc_addr         (rc_addr),
        .ra_used         (ra_used),
        .rb_used         (rb_used),
        .rc_used         (rc_used),
        .issue_ready     (issue_ready),
        .sp_fire         (sp_fire),
        .busy            (busy),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int sat_stalls(input int n);
        return (n > 65535) ? 65535 : n;
    endfunction

    // Present one instruction, hold it until accepted, then drop valid.
    // Called just after a rising edge; returns just after the accept edge.
    task automatic applyStimulus(input logic is_int, input logic wr,
                                 input logic [6:0] rt,
                                 input logic [6:0] ra, input logic ra_u,
                                 input logic [6:0] rb, input logic rb_u,
                                 input logic [6:0] rc, input logic rc_u,
                                 input int stalls);
        exp_t e;
        int   waited;
        logic accepted;
        issue_is_int    = is_int;
        issue_reg_write = wr;
        issue_rt_addr   = rt;
        ra_addr         = ra;
        ra_used         = ra_u;
        rb_addr         = rb;
        rb_used         = rb_u;
        rc_addr         = rc;
        rc_used         = rc_u;
        issue_valid     = 1'b1;
        e.cyc = cyc + stalls;
        e.rt  = rt;
        sb_queue.push_back(e);
        model_stalls += stalls;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 40) begin
            @(negedge clk);
            if (sp_fire) accepted = 1'b1;
            waited++;
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: rt=%0d not accepted in 40 cycles", rt);
            void'(sb_queue.pop_back());
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accept must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && sp_fire) begin
            if (sb_queue.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected accept: rt=%0d at cycle %0d, expected none",
                         issue_rt_addr, cyc);
            end else begin
                e = sb_queue.pop_front();
                checkOutput("accept cycle", cyc, e.cyc);
                checkOutput("accept rt", 32'(issue_rt_addr), 32'(e.rt));
            end
        end
    end

    initial begin
        int port_stall;
        reset           = 1'b1;
        issue_valid     = 1'b0;
        issue_is_int    = 1'b0;
        issue_reg_write = 1'b0;
        issue_rt_addr   = '0;
        ra_addr         = '0;
        rb_addr         = '0;
        rc_addr         = '0;
        ra_used         = 1'b0;
        rb_used         = 1'b0;
        rc_used         = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);

        $display("[TB] reset state");
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset stall_count", 32'(stall_count), 0);
        checkOutput("reset issue_ready", 32'(issue_ready), 1);
        checkOutput("reset sp_fire", 32'(sp_fire), 0);

        $display("[TB] FP RAW spacing");
        applyStimulus(0, 1, 7'd5,  7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        applyStimulus(0, 1, 7'd6,  7'd5, 1, 7'd0, 0, 7'd0, 0, 5);
        checkOutput("stall_count after FP RAW", 32'(stall_count), 5);
        wait_cycles(10);

        $display("[TB] int RAW spacing");
        applyStimulus(1, 1, 7'd9,  7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        applyStimulus(0, 1, 7'd10, 7'd0, 0, 7'd9, 1, 7'd0, 0, 6);
        checkOutput("stall_count after int RAW", 32'(stall_count), 11);
        wait_cycles(10);

        $display("[TB] WAW int then FP same dest");
        applyStimulus(1, 1, 7'd3,  7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        applyStimulus(0, 1, 7'd3,  7'd40, 1, 7'd0, 0, 7'd0, 0, 1);
        checkOutput("stall_count after WAW", 32'(stall_count), 12);
        wait_cycles(10);

        $display("[TB] int then FP different dest");
`ifdef SP_WB_PORT_SHARE_EN
        port_stall = 1;
`else
        port_stall = 0;
`endif
        applyStimulus(1, 1, 7'd3,  7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        applyStimulus(0, 1, 7'd4,  7'd41, 1, 7'd0, 0, 7'd0, 0, port_stall);
        checkOutput("stall_count after port case", 32'(stall_count), 32'(12 + port_stall));
        wait_cycles(10);

        $display("[TB] unused source and non-writing producer");
        applyStimulus(0, 1, 7'd11, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        applyStimulus(0, 1, 7'd13, 7'd0, 0, 7'd0, 0, 7'd11, 0, 0);
        applyStimulus(0, 0, 7'd12, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        applyStimulus(0, 1, 7'd14, 7'd12, 1, 7'd0, 0, 7'd0, 0, 0);
        checkOutput("stall_count after no-hazard ops", 32'(stall_count), 32'(12 + port_stall));
        wait_cycles(10);

        $display("[TB] eight back-to-back FP ops");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 7'(60 + i), 7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        end
        checkOutput("busy at last accept", 32'(busy), 1);
        for (int k = 1; k <= 6; k++) begin
            wait_cycles(1);
            checkOutput("busy draining", 32'(busy), 1);
        end
        wait_cycles(1);
        checkOutput("busy after drain", 32'(busy), 0);
        wait_cycles(5);

        $display("[TB] stall counter saturation");
        applyStimulus(1, 1, 7'd9, 7'd9, 1, 7'd0, 0, 7'd0, 0, 0);
        while (model_stalls < 65547) begin
            applyStimulus(1, 1, 7'd9, 7'd9, 1, 7'd0, 0, 7'd0, 0, 6);
            if (model_stalls > 30000 && model_stalls <= 30006) begin
                checkOutput("stall_count mid-run", 32'(stall_count), 32'(sat_stalls(model_stalls)));
            end
        end
        checkOutput("stall_count saturated", 32'(stall_count), 32'(sat_stalls(model_stalls)));
        wait_cycles(10);

        $display("[TB] async reset mid-stall");
        applyStimulus(1, 1, 7'd20, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0);
        issue_is_int    = 1'b0;
        issue_reg_write = 1'b1;
        issue_rt_addr   = 7'd21;
        ra_addr         = 7'd20;
        ra_used         = 1'b1;
        rb_used         = 1'b0;
        rc_used         = 1'b0;
        issue_valid     = 1'b1;
        @(negedge clk);
        checkOutput("stalled issue_ready", 32'(issue_ready), 0);
        @(negedge clk);
        checkOutput("stalled busy", 32'(busy), 1);
        #2;
        reset       = 1'b1;
        issue_valid = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busy), 0);
        checkOutput("async reset issue_ready", 32'(issue_ready), 1);
        checkOutput("async reset stall_count", 32'(stall_count), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(3);
        checkOutput("scoreboard empty", 32'(sb_queue.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_issue_scheduler.md
# sp_issue_scheduler

Issue controller for the single-precision pipe. It sits between decode and the RF/FWD stage of `SinglePrecision` and gates every instruction with a valid/ready handshake. A 7-slot in-flight tracker records every accepted instruction's destination, write flag and latency class (FP = 6, integer mpy = 7). New instructions are held off until RAW, WAW and optional write-port hazards against in-flight entries clear.

## Interface
- `DEPTH`, default 7: number of in-flight tracker slots; must be at least `INT_LAT`.
- `STALL_W`, default 16: width of the saturating stall counter.
- `clk` input 1: pipeline clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `issue_valid` input 1: decode presents an instruction.
- `issue_is_int` input 1: 1 = integer op (latency 7, result on `rt_int`); 0 = FP op (latency 6, result on `rt_wb`).
- `issue_reg_write` input 1: instruction writes `issue_rt_addr`.
- `issue_rt_addr` input [0:6]: destination register.
- `ra_addr`, `rb_addr`, `rc_addr` input [0:6]: source registers.
- `ra_used`, `rb_used`, `rc_used` input 1: the source is actually read.
- `issue_ready` output 1: scheduler accepts this cycle.
- `sp_fire` output 1: equals `issue_valid & issue_ready`. Qualifies the SP unit inputs; when low, the SP unit is fed a nop.
- `busy` output 1: any tracker slot valid.
- `stall_count` output [0:STALL_W-1]: cycles where `issue_valid & !issue_ready`, saturating.

## Operation
- Tracker entry fields: `valid`, `is_int`, `wr`, `rt[0:6]`. On accept, the entry loads into slot 0. Every edge, slot i moves to slot i+1, and an invalid entry enters slot 0 when there is no accept. The entry in slot DEPTH-1 drops off.
- Latency rule: L = 6 (FP) or 7 (int). An entry accepted at edge t has its result visible to a consumer accepted at edge t+L or later. It is therefore "pending" while in slot i with i < L-1.
- RAW: stall if any pending entry has `wr`=1 and `rt` equal to a source whose `*_used`=1.
- WAW: stall if slot 0 holds a valid int entry with `wr`=1, the new op is FP with `issue_reg_write`=1, and the addresses match. Both would otherwise complete on the same edge.
- Entries with `wr`=0 (nop, store-like) never cause a stall, but they do occupy slots.
- `issue_ready` = no RAW, no WAW, and (when configured) no port conflict. It is independent of `issue_valid`.
- `stall_count` increments by 1 per stalled cycle and holds at all-ones.

## Timing
- `issue_ready` and `sp_fire` are combinational from the tracker state and the current issue fields. The tracker, `busy` and `stall_count` are registered.
- Accept and shift happen on the same edge; there is no bubble between back-to-back independent ops.
- Minimum dependent spacing: FP producer accepted at edge t lets its consumer be accepted at t+6 (5 stall cycles when presented at t+1). Int producer: t+7 (6 stall cycles).
- Values after reset: all slots invalid, `busy`=0, `stall_count`=0, `issue_ready`=1, `sp_fire`=`issue_valid`.
- Reset mid-operation clears the tracker. Results still draining from the SP unit are the SP unit's own reset concern.

## Configuration
- `SP_WB_PORT_SHARE_EN`, defined: `rt_wb` and `rt_int` share one register-file write port. Any FP op with `issue_reg_write`=1 stalls while slot 0 holds an int entry with `wr`=1, whatever the addresses. This forces exactly one stall cycle.
- Undefined: separate ports; only RAW and WAW stall.

## Structure
- `sp_sched_pkg`: `FP_LAT`=6, `INT_LAT`=7, `REG_ADDR_W`=7, typedef `sp_slot_t` (valid, is_int, wr, rt).
- One sub-module, `sp_slot_match`: combinational per-slot match of one entry against the three sources and the destination. It returns raw_hit and waw_hit using slot index and latency. It is instantiated DEPTH times; the top ORs the hits.

## Test plan
- Reset, then FP to r5 at edge 0 followed immediately by an FP op reading `ra`=r5 → `issue_ready`=0 for 5 cycles, accepted at edge 6, `stall_count`=5.
- Int mpy to r9, then an op reading `rb`=r9 → 6 stall cycles, accepted at edge 7.
- Int to r3, next cycle FP writing r3 with an unrelated source → 1 stall cycle (WAW). Repeat writing r4: no stall without the macro, 1 stall with `SP_WB_PORT_SHARE_EN`.
- Source match with `rc_used`=0, or producer with `issue_reg_write`=0 → no stall; 8 back-to-back independent FP ops → 8 accepts in 8 cycles, `busy`=1 until 7 edges after the last accept.
- Hold a dependent stalled for 70000 cycles → `stall_count` saturates at 16'hFFFF.
- Assert `reset` asynchronously mid-stall → `busy`=0 and `issue_ready`=1 immediately, without waiting for a clock edge.
